// File: rtl/vga_frame_capture.sv
// VGA receive side: recovers pixel/line position, verifies line and frame timing, and once locked
// writes a 2x2-decimated window of the source into a 256x256 x 9-bit VRAM port.
module vga_frame_capture #(
    parameter int unsigned H_ACT = 800,
    parameter int unsigned V_ACT = 600,
    parameter int unsigned CAP_W = 512,
    parameter int unsigned CAP_H = 512
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iVGA_HS,
    input  logic       iVGA_VS,
    input  logic       iVGA_BLANK,
    input  logic [7:0] iVGA_R,
    input  logic [7:0] iVGA_G,
    input  logic [7:0] iVGA_B,
    output logic [7:0] write_x,
    output logic [7:0] write_y,
    output logic [2:0] write_r,
    output logic [2:0] write_g,
    output logic [2:0] write_b,
    output logic       write_en,
    output logic       oLocked,
    output logic       oFrame_Done,
    output logic       oErr
);

    localparam logic [1:0]  S_SEARCH  = 2'd0;
    localparam logic [1:0]  S_MEASURE = 2'd1;
    localparam logic [1:0]  S_LOCKED  = 2'd2;
    localparam logic [10:0] CNT_MAX   = 11'h7FF;

    logic        r_vs1, r_blank1, r_vs2, r_blank2;
    logic [2:0]  r_r1, r_g1, r_b1;
    logic [10:0] r_px, r_ly;
    logic        r_lerr;
    logic [1:0]  r_state;
    logic [7:0]  r_wx, r_wy;
    logic [2:0]  r_wr, r_wg, r_wb;
    logic        r_wen, r_locked, r_done, r_err;

    logic        w_blank_fall, w_vs_fall;
    logic [10:0] w_ly_inc, w_ly_line;
    logic        w_line_err, w_frame_err, w_capture;
    logic [1:0]  w_state_next;
    logic        w_err_next, w_done_next;

    // HS carries no information the BLANK/VS edges do not already give; low colour bits are dropped.
    logic w_unused;
    assign w_unused = ^{iVGA_HS, iVGA_R[4:0], iVGA_G[4:0], iVGA_B[4:0]};

    assign w_blank_fall = r_blank2 & ~r_blank1;
    assign w_vs_fall    = r_vs2 & ~r_vs1;
    assign w_ly_inc     = (r_ly == CNT_MAX) ? r_ly : r_ly + 11'd1;
    // Line count as it stands after any line ending this cycle, so a coincident VS sees it.
    assign w_ly_line    = w_blank_fall ? w_ly_inc : r_ly;
    assign w_line_err   = w_blank_fall && (r_px != 11'(H_ACT));
    assign w_frame_err  = r_lerr || w_line_err || (w_ly_line != 11'(V_ACT));
    assign w_capture    = (r_state == S_LOCKED) && r_blank1 &&
                          (r_px < 11'(CAP_W)) && (r_ly < 11'(CAP_H)) && !r_px[0] && !r_ly[0];

    always_comb begin
        w_state_next = r_state;
        w_err_next   = 1'b0;
        w_done_next  = 1'b0;
        case (r_state)
            S_SEARCH: begin
                if (w_vs_fall) w_state_next = S_MEASURE;
            end
            S_MEASURE: begin
                if (w_vs_fall) begin
                    if (w_frame_err) w_err_next   = 1'b1;
                    else             w_state_next = S_LOCKED;
                end
            end
            S_LOCKED: begin
                if (w_vs_fall) begin
                    if (w_frame_err) begin
                        w_err_next   = 1'b1;
                        w_state_next = S_MEASURE;
                    end else begin
                        w_done_next  = 1'b1;
                    end
                end else if (w_line_err) begin
                    w_err_next   = 1'b1;
                    w_state_next = S_MEASURE;
                end
            end
            default: w_state_next = S_SEARCH;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_vs1    <= 1'b0;
            r_blank1 <= 1'b0;
            r_vs2    <= 1'b0;
            r_blank2 <= 1'b0;
            r_r1     <= 3'd0;
            r_g1     <= 3'd0;
            r_b1     <= 3'd0;
            r_px     <= 11'd0;
            r_ly     <= 11'd0;
            r_lerr   <= 1'b0;
            r_state  <= S_SEARCH;
            r_wx     <= 8'd0;
            r_wy     <= 8'd0;
            r_wr     <= 3'd0;
            r_wg     <= 3'd0;
            r_wb     <= 3'd0;
            r_wen    <= 1'b0;
            r_locked <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_vs1    <= iVGA_VS;
            r_blank1 <= iVGA_BLANK;
            r_vs2    <= r_vs1;
            r_blank2 <= r_blank1;
            r_r1     <= iVGA_R[7:5];
            r_g1     <= iVGA_G[7:5];
            r_b1     <= iVGA_B[7:5];

            if (w_blank_fall)                      r_px <= 11'd0;
            else if (r_blank1 && r_px != CNT_MAX)  r_px <= r_px + 11'd1;

            if (w_vs_fall)         r_ly <= 11'd0;
            else if (w_blank_fall) r_ly <= w_ly_inc;

            if (w_vs_fall)       r_lerr <= 1'b0;
            else if (w_line_err) r_lerr <= 1'b1;

            r_state  <= w_state_next;
            r_locked <= (w_state_next == S_LOCKED);
            r_done   <= w_done_next;
            r_err    <= w_err_next;

            r_wen <= w_capture;
            if (w_capture) begin
                r_wx <= r_px[8:1];
                r_wy <= r_ly[8:1];
                r_wr <= r_r1;
                r_wg <= r_g1;
                r_wb <= r_b1;
            end
        end
    end

    assign write_x     = r_wx;
    assign write_y     = r_wy;
    assign write_r     = r_wr;
    assign write_g     = r_wg;
    assign write_b     = r_wb;
    assign write_en    = r_wen;
    assign oLocked     = r_locked;
    assign oFrame_Done = r_done;
    assign oErr        = r_err;

endmodule

// File: tb/tb_vga_frame_capture.sv
// Bench for vga_frame_capture on a scaled-down raster (16x12 active, 8x8 capture window).
module tb_vga_frame_capture;

    localparam int H  = 16;
    localparam int V  = 12;
    localparam int CW = 8;
    localparam int CH = 8;
    localparam int HB = 4;
    localparam int VB = 3;

    logic       iCLK = 1'b0;
    logic       iRST = 1'b1;
    logic       iVGA_HS = 1'b1, iVGA_VS = 1'b1, iVGA_BLANK = 1'b0;
    logic [7:0] iVGA_R = 8'd0, iVGA_G = 8'd0, iVGA_B = 8'd0;
    logic [7:0] write_x, write_y;
    logic [2:0] write_r, write_g, write_b;
    logic       write_en, oLocked, oFrame_Done, oErr;

    vga_frame_capture #(.H_ACT(H), .V_ACT(V), .CAP_W(CW), .CAP_H(CH)) dut (
        .iCLK(iCLK), .iRST(iRST), .iVGA_HS(iVGA_HS), .iVGA_VS(iVGA_VS),
        .iVGA_BLANK(iVGA_BLANK), .iVGA_R(iVGA_R), .iVGA_G(iVGA_G), .iVGA_B(iVGA_B),
        .write_x(write_x), .write_y(write_y), .write_r(write_r), .write_g(write_g),
        .write_b(write_b), .write_en(write_en), .oLocked(oLocked),
        .oFrame_Done(oFrame_Done), .oErr(oErr)
    );

    always #5 iCLK = ~iCLK;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int mode     = 0;
    int cnt_wr   = 0, cnt_err = 0, cnt_done = 0;
    int t_lat[3] = '{-100, -100, -100};

    always @(posedge iCLK) cyc = cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    // Source pattern: mode 0 is a ramp, mode 1 is black with white at (0,0), (1,0) and (8,0).
    function automatic logic [23:0] pix(input int p, input int l, input int m);
        logic [7:0] r, g, b;
        if (m == 0) begin
            r = 8'(p * 32);
            g = 8'(l * 32);
            b = 8'((p + l) * 32);
            return {r, g, b};
        end
        if (l == 0 && (p == 0 || p == 1 || p == 8)) return 24'hFFFFFF;
        return 24'h000000;
    endfunction

    function automatic int exp_rgb(input int p, input int l, input int m);
        logic [23:0] v;
        v = pix(p, l, m);
        return int'({v[23:21], v[15:13], v[7:5]});
    endfunction

    always @(negedge iCLK) begin
        if (write_en) begin
            cnt_wr++;
            check("wr_x_in_window", int'(write_x < 8'(CW / 2)), 1);
            check("wr_y_in_window", int'(write_y < 8'(CH / 2)), 1);
            check("wr_rgb", int'({write_r, write_g, write_b}),
                  exp_rgb(2 * int'(write_x), 2 * int'(write_y), mode));
        end
        if (oErr)        cnt_err++;
        if (oFrame_Done) cnt_done++;
        if (cyc == t_lat[0] + 2) begin
            check("lat_px00_en", int'(write_en), 1);
            check("lat_px00_xy", int'({write_x, write_y}), 0);
            check("lat_px00_rgb", int'({write_r, write_g, write_b}), 9'h1FF);
        end
        if (cyc == t_lat[1] + 2) check("lat_px10_no_write", int'(write_en), 0);
        if (cyc == t_lat[2] + 2) check("lat_px80_no_write", int'(write_en), 0);
    end

    task automatic check_all_zero(input string name);
        check(name, int'({write_x, write_y, write_r, write_g, write_b,
                          write_en, oLocked, oFrame_Done, oErr}), 0);
    endtask

    task automatic gen_frame(input int nl, input int short_l, input int coinc, input int m);
        for (int l = 0; l < nl; l++) begin
            int len;
            len = (l == short_l) ? H - 1 : H;
            for (int p = 0; p < len; p++) begin
                iVGA_BLANK = 1'b1;
                {iVGA_R, iVGA_G, iVGA_B} = pix(p, l, m);
                if (m == 1 && l == 0) begin
                    if (p == 0) t_lat[0] = cyc;
                    if (p == 1) t_lat[1] = cyc;
                    if (p == 8) t_lat[2] = cyc;
                end
                tick();
            end
            if (coinc != 0 && l == nl - 1) iVGA_VS = 1'b0;
            for (int h = 0; h < HB; h++) begin
                iVGA_BLANK = 1'b0;
                {iVGA_R, iVGA_G, iVGA_B} = 24'h0;
                iVGA_HS = !(h == 1 || h == 2);
                tick();
            end
        end
        for (int vl = 0; vl < VB; vl++) begin
            for (int c = 0; c < H + HB; c++) begin
                iVGA_BLANK = 1'b0;
                iVGA_HS = !(c == H + 1 || c == H + 2);
                iVGA_VS = (coinc != 0) ? (vl != 0) : (vl != 1);
                tick();
            end
        end
        iVGA_VS = 1'b1;
    endtask

    typedef struct {
        string name;
        int    nl, short_l, coinc, mode, rst;
        int    exp_wr, exp_err, exp_done, exp_lock;
    } frame_vec_t;

    frame_vec_t vecs[12];

    initial begin
        //               name            nl  short coinc mode rst  wr err done lock
        vecs[0]  = '{"search",       V,  -1,   0,    0,   0,   0,  0,  0,   0};
        vecs[1]  = '{"measure",      V,  -1,   0,    0,   0,   0,  0,  0,   1};
        vecs[2]  = '{"locked",       V,  -1,   0,    0,   0,  16,  0,  1,   1};
        vecs[3]  = '{"short_line",   V,   3,   0,    0,   0,   8,  2,  0,   0};
        vecs[4]  = '{"relock",       V,  -1,   0,    0,   0,   0,  0,  0,   1};
        vecs[5]  = '{"short_frame",  V-1, -1,  0,    0,   0,  16,  1,  0,   0};
        vecs[6]  = '{"relock2",      V,  -1,   0,    0,   0,   0,  0,  0,   1};
        vecs[7]  = '{"coincident",   V,  -1,   1,    0,   0,  16,  0,  1,   1};
        vecs[8]  = '{"latency",      V,  -1,   0,    1,   0,  16,  0,  1,   1};
        vecs[9]  = '{"rst_search",   V,  -1,   0,    0,   1,   0,  0,  0,   0};
        vecs[10] = '{"rst_measure",  V,  -1,   0,    0,   0,   0,  0,  0,   1};
        vecs[11] = '{"rst_locked",   V,  -1,   0,    0,   0,  16,  0,  1,   1};

        repeat (3) tick();
        check_all_zero("reset_state");
        iRST = 1'b0;
        tick();
        check_all_zero("post_reset_idle");

        for (int i = 0; i < 12; i++) begin
            mode = vecs[i].mode;
            if (vecs[i].rst != 0) begin
                check("pre_reset_locked", int'(oLocked), 1);
                for (int p = 0; p < 6; p++) begin
                    iVGA_BLANK = 1'b1;
                    {iVGA_R, iVGA_G, iVGA_B} = pix(p, 0, 0);
                    tick();
                end
                iRST = 1'b1;
                repeat (3) tick();
                check_all_zero("midline_reset_outputs");
                iRST = 1'b0;
                iVGA_BLANK = 1'b0;
                repeat (HB) tick();
            end
            cnt_wr = 0;
            cnt_err = 0;
            cnt_done = 0;
            gen_frame(vecs[i].nl, vecs[i].short_l, vecs[i].coinc, vecs[i].mode);
            tick();
            check({vecs[i].name, "_writes"}, cnt_wr, vecs[i].exp_wr);
            check({vecs[i].name, "_err"}, cnt_err, vecs[i].exp_err);
            check({vecs[i].name, "_done"}, cnt_done, vecs[i].exp_done);
            check({vecs[i].name, "_locked"}, int'(oLocked), vecs[i].exp_lock);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
